// File: rtl/sum_batch_pkg.sv
// sum_batch_pkg
// Shared types and default sizing for the batch accumulator that sits behind
// the 6-bit adder stage (7-bit sum words: carry-out in the MSB).

package sum_batch_pkg;

    // Batch FSM: waiting for first sample, collecting samples, result held.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ACCUM = 2'b01,
        DONE  = 2'b10
    } state_t;

    // Defaults: 7-bit sums, 10-bit accumulator (holds 4*127 = 508), 4 samples.
    localparam int SUM_W_DEF = 7;
    localparam int ACC_W_DEF = 10;
    localparam int COUNT_DEF = 4;

endpackage

// File: rtl/sum_batch_addsat.sv
// sum_batch_addsat
// Combinational add of a zero-extended sum word into the accumulator.
// The addition is done one bit wider than the accumulator so the carry into
// bit ACC_W flags an overflow.
// Build option: define SUM_BATCH_SATURATE_EN to clamp the result at all-ones
// on overflow; otherwise the result wraps modulo 2^ACC_W. Once clamped, any
// further non-zero addend overflows again, so the value stays pinned at the
// maximum for the rest of the batch.

module sum_batch_addsat
    import sum_batch_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [SUM_W-1:0] sum,
    output logic [ACC_W-1:0] acc_next,
    output logic             overflow
);

    logic [ACC_W:0] sum_ext;
    logic [ACC_W:0] wide_sum;

    // Zero-extend the whole sum word (the carry bit is part of the value).
    assign sum_ext  = {{(ACC_W + 1 - SUM_W){1'b0}}, sum};
    assign wide_sum = {1'b0, acc} + sum_ext;
    assign overflow = wide_sum[ACC_W];

`ifdef SUM_BATCH_SATURATE_EN
    // Clamp to the largest representable value when the add overflows.
    assign acc_next = overflow ? {ACC_W{1'b1}} : wide_sum[ACC_W-1:0];
`else
    // Plain wrap-around: drop the carry out of the accumulator width.
    assign acc_next = wide_sum[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_batch_accumulator.sv
// sum_batch_accumulator
// Collects COUNT adder results over a valid/ready handshake, sums them into
// a wider accumulator, counts how many carried out, and holds the batch total
// on an output handshake until the consumer takes it.
// Build option: SUM_BATCH_SATURATE_EN selects saturating accumulation inside
// sum_batch_addsat; counters and handshake are the same in both builds.
// COUNT must lie in 2..15; CNT_W is derived and should not be overridden.

module sum_batch_accumulator
    import sum_batch_pkg::*;
#(
    parameter int SUM_W = SUM_W_DEF,
    parameter int ACC_W = ACC_W_DEF,
    parameter int COUNT = COUNT_DEF,
    parameter int CNT_W = $clog2(COUNT + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic [SUM_W-1:0] sum_in,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [ACC_W-1:0] acc_out,
    output logic [CNT_W-1:0] carry_cnt,
    output logic             ovf,
    output logic             out_valid,
    input  logic             out_ready
);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             accept;
    logic             last_sample;
    logic [CNT_W-1:0] carry_inc;
    logic [ACC_W-1:0] acc_sum;
    logic             add_ovf;

    // Input side is open whenever no finished result is being held, so a
    // result transfer and a new sample can never share a cycle.
    assign in_ready    = (state != DONE);
    assign accept      = in_valid && in_ready;
    assign last_sample = (count == CNT_W'(COUNT - 1));
    assign carry_inc   = {{(CNT_W - 1){1'b0}}, sum_in[SUM_W-1]};

    sum_batch_addsat #(
        .SUM_W (SUM_W),
        .ACC_W (ACC_W)
    ) u_addsat (
        .acc      (acc_out),
        .sum      (sum_in),
        .acc_next (acc_sum),
        .overflow (add_ovf)
    );

    // Batch FSM with its counters; clear overrides both accept and transfer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            acc_out   <= '0;
            carry_cnt <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else if (clear) begin
            state     <= IDLE;
            acc_out   <= '0;
            carry_cnt <= '0;
            count     <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE, ACCUM: begin
                    if (accept) begin
                        acc_out   <= acc_sum;
                        count     <= count + 1'b1;
                        carry_cnt <= carry_cnt + carry_inc;
                        ovf       <= ovf | add_ovf;
                        if (last_sample) begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ACCUM;
                        end
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        acc_out   <= '0;
                        carry_cnt <= '0;
                        count     <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sum_batch_accumulator.sv
// tb_sum_batch_accumulator
// Drives two accumulators in lockstep from the same stimulus: one with the
// default 10-bit accumulator and one with an 8-bit accumulator so that the
// overflow path (wrap or saturate, depending on SUM_BATCH_SATURATE_EN) is
// exercised. Expected batch results come from a small behavioural model and
// are queued per instance, then popped when out_valid is seen.

module tb_sum_batch_accumulator;

`ifdef SUM_BATCH_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    typedef struct {
        logic [31:0] acc;
        logic [31:0] carry;
        logic [31:0] ovf;
    } res_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [6:0] sum_in = '0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready_a, ovf_a, out_valid_a;
    logic [9:0] acc_a;
    logic [2:0] carry_a;
    logic       in_ready_b, ovf_b, out_valid_b;
    logic [7:0] acc_b;
    logic [2:0] carry_b;

    int checks = 0;
    int errors = 0;

    int unsigned batch[$];
    res_t        sb_a[$];
    res_t        sb_b[$];

    sum_batch_accumulator dut_a (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sum_in    (sum_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_a),
        .acc_out   (acc_a),
        .carry_cnt (carry_a),
        .ovf       (ovf_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready)
    );

    sum_batch_accumulator #(.ACC_W(8)) dut_b (
        .clk       (clk),
        .rst       (rst),
        .clear     (clear),
        .sum_in    (sum_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready_b),
        .acc_out   (acc_b),
        .carry_cnt (carry_b),
        .ovf       (ovf_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    // Reference model of one complete batch for a given accumulator width.
    function automatic res_t model_batch(input int unsigned samples[$], input int acc_w);
        res_t r;
        int unsigned maxv;
        int unsigned total;
        maxv    = (32'd1 << acc_w) - 1;
        total   = 0;
        r.carry = 0;
        r.ovf   = 0;
        foreach (samples[i]) begin
            total = total + samples[i];
            if (((samples[i] >> 6) & 1) == 1) r.carry = r.carry + 1;
            if (total > maxv) begin
                r.ovf = 1;
                total = SAT ? maxv : (total - (maxv + 1));
            end
        end
        r.acc = total;
        return r;
    endfunction

    task automatic check_val(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Record an accepted sample; a full batch turns into queued expectations.
    task automatic record_sample(input logic [6:0] v);
        batch.push_back(int'(v));
        if (batch.size() == 4) begin
            sb_a.push_back(model_batch(batch, 10));
            sb_b.push_back(model_batch(batch, 8));
            batch.delete();
        end
    endtask

    // Present one sample and wait (bounded) until it is accepted.
    task automatic apply_stimulus(input logic [6:0] v);
        int waits;
        waits    = 0;
        in_valid = 1'b1;
        sum_in   = v;
        while (in_ready_a !== 1'b1 && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        check_val("accept_within_bound", (waits < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        #1;
        record_sample(v);
        in_valid = 1'b0;
        sum_in   = 7'($urandom);
    endtask

    // Wait for a result, compare against the scoreboard, then take it.
    task automatic check_output(input string tag);
        int   waits;
        res_t ea;
        res_t eb;
        waits = 0;
        while (out_valid_a !== 1'b1 && waits < 50) begin
            @(posedge clk);
            #1;
            waits++;
        end
        check_val({tag, "_out_valid"}, {31'd0, out_valid_a}, 32'd1);
        if (sb_a.size() == 0 || sb_b.size() == 0) begin
            errors++;
            $error("[TB] FAIL %s_scoreboard: observed empty expected entry", tag);
        end else begin
            ea = sb_a.pop_front();
            eb = sb_b.pop_front();
            check_val({tag, "_acc_a"}, {22'd0, acc_a}, ea.acc);
            check_val({tag, "_carry_a"}, {29'd0, carry_a}, ea.carry);
            check_val({tag, "_ovf_a"}, {31'd0, ovf_a}, ea.ovf);
            check_val({tag, "_acc_b"}, {24'd0, acc_b}, eb.acc);
            check_val({tag, "_carry_b"}, {29'd0, carry_b}, eb.carry);
            check_val({tag, "_ovf_b"}, {31'd0, ovf_b}, eb.ovf);
            check_val({tag, "_out_valid_b"}, {31'd0, out_valid_b}, 32'd1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check_val({tag, "_post_valid"}, {31'd0, out_valid_a}, 32'd0);
        check_val({tag, "_post_acc"}, {22'd0, acc_a}, 32'd0);
        check_val({tag, "_post_ready"}, {31'd0, in_ready_a}, 32'd1);
        check_val({tag, "_post_ovf_b"}, {31'd0, ovf_b}, 32'd0);
    endtask

    // Safety net in case the design wedges in a way the bounded waits miss.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset values while rst is held.
        #3;
        check_val("rst_acc", {22'd0, acc_a}, 32'd0);
        check_val("rst_carry", {29'd0, carry_a}, 32'd0);
        check_val("rst_ovf", {31'd0, ovf_a}, 32'd0);
        check_val("rst_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_val("rst_in_ready", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic batch, running value and one-cycle result latency.
        apply_stimulus(7'd10);
        check_val("run_acc_10", {22'd0, acc_a}, 32'd10);
        apply_stimulus(7'd20);
        apply_stimulus(7'd30);
        apply_stimulus(7'd40);
        check_val("latency_out_valid", {31'd0, out_valid_a}, 32'd1);
        check_output("b100");

        // All carries set; wide accumulator just fits, narrow one overflows.
        for (int i = 0; i < 4; i++) apply_stimulus(7'h7F);
        check_output("b508");

        // Overflow at 8 bits on the third sample.
        apply_stimulus(7'd100);
        apply_stimulus(7'd100);
        apply_stimulus(7'd100);
        apply_stimulus(7'd0);
        check_output("b300");

        // Hold the result while junk samples are offered.
        apply_stimulus(7'd1);
        apply_stimulus(7'd2);
        apply_stimulus(7'd3);
        apply_stimulus(7'd4);
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            sum_in   = 7'($urandom);
            @(posedge clk);
            #1;
            check_val("hold_in_ready", {31'd0, in_ready_a}, 32'd0);
            check_val("hold_out_valid", {31'd0, out_valid_a}, 32'd1);
            check_val("hold_acc", {22'd0, acc_a}, sb_a[0].acc);
            check_val("hold_carry", {29'd0, carry_a}, sb_a[0].carry);
        end
        // Transfer with a sample already waiting: it must not be taken yet.
        sum_in    = 7'd9;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        void'(sb_a.pop_front());
        void'(sb_b.pop_front());
        check_val("xfer_out_valid", {31'd0, out_valid_a}, 32'd0);
        check_val("xfer_acc", {22'd0, acc_a}, 32'd0);
        @(posedge clk);
        #1;
        record_sample(7'd9);
        in_valid = 1'b0;
        check_val("fresh_acc", {22'd0, acc_a}, 32'd9);
        apply_stimulus(7'd9);
        apply_stimulus(7'd9);
        apply_stimulus(7'd9);
        check_output("b36");

        // Asynchronous reset in the middle of a cycle discards the batch.
        apply_stimulus(7'd10);
        apply_stimulus(7'd20);
        check_val("pre_rst_acc", {22'd0, acc_a}, 32'd30);
        #3;
        rst = 1'b1;
        #1;
        check_val("async_rst_acc", {22'd0, acc_a}, 32'd0);
        check_val("async_rst_acc_b", {24'd0, acc_b}, 32'd0);
        check_val("async_rst_carry", {29'd0, carry_a}, 32'd0);
        check_val("async_rst_ready", {31'd0, in_ready_a}, 32'd1);
        batch.delete();
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) apply_stimulus(7'd1);
        check_output("b4");

        // Clear wins over a simultaneous accept; the sample is dropped.
        apply_stimulus(7'd20);
        apply_stimulus(7'd10);
        clear    = 1'b1;
        in_valid = 1'b1;
        sum_in   = 7'd50;
        #1;
        check_val("clear_in_ready", {31'd0, in_ready_a}, 32'd1);
        @(posedge clk);
        #1;
        clear    = 1'b0;
        in_valid = 1'b0;
        batch.delete();
        check_val("clear_acc", {22'd0, acc_a}, 32'd0);
        check_val("clear_carry", {29'd0, carry_a}, 32'd0);
        check_val("clear_out_valid", {31'd0, out_valid_a}, 32'd0);
        apply_stimulus(7'd1);
        apply_stimulus(7'd2);
        apply_stimulus(7'd3);
        check_val("clear_count_reset", {31'd0, out_valid_a}, 32'd0);
        apply_stimulus(7'd4);
        check_output("b10");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
